// File: rtl/rtx_pattern_gen.sv
// Interleaved raster pattern generator: presents one pixel at a time on a
// valid/ready port, with a programmable idle gap and four colour patterns.
module rtx_pattern_gen #(
    parameter int unsigned H_SIZE      = 1280,
    parameter int unsigned V_SIZE      = 720,
    parameter int unsigned STRIDE      = 8,
    parameter int unsigned WAIT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        pause,
    input  logic [1:0]  mode,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [10:0] out_h,
    output logic [9:0]  out_v,
    output logic [23:0] out_color,
    output logic [15:0] out_pixel565,
    output logic [7:0]  out_frame,
    output logic        out_first,
    output logic        frame_done
);

    localparam int unsigned CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CNT_INIT_I = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(CNT_INIT_I);
    localparam logic [10:0]      BASE_LAST  = 11'(H_SIZE - STRIDE);
    localparam logic [10:0]      PHASE_LAST = 11'(STRIDE - 1);
    localparam logic [10:0]      STRIDE_W   = 11'(STRIDE);
    localparam logic [9:0]       V_LAST     = 10'(V_SIZE - 1);

    typedef enum logic {ST_WAIT, ST_EMIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [10:0]       base_q, base_d;
    logic [10:0]       phase_q, phase_d;
    logic [10:0]       h_q, h_d;
    logic [9:0]        v_q, v_d;
    logic [7:0]        frame_q, frame_d;
    logic [23:0]       color_q, color_d;
    logic              first_q, first_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              load;

    // Colour of a pixel, packed {B,G,R}.
    function automatic logic [23:0] color_f(input logic [1:0] m, input logic [10:0] h,
                                            input logic [7:0] v, input logic [7:0] f);
        logic [7:0] r, g, b;
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        case (m)
            2'd0: begin
                r = 8'hFF;
                g = (f[2:0] > h[7:5]) ? 8'hFF : 8'h00;
                b = (f[5:3] > v[6:4]) ? 8'hFF : 8'h00;
            end
            2'd1: begin
                r = h[7:0];
                g = v;
                b = f;
            end
            2'd2: begin
                r = (h[5] ^ v[5]) ? 8'hFF : 8'h00;
                g = r;
                b = r;
            end
            default: begin
                r = {8{h[8]}};
                g = {8{h[9]}};
                b = {8{h[10]}};
            end
        endcase
        return {b, g, r};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = 1'b1;
        base_d  = base_q;
        phase_d = phase_q;
        v_d     = v_q;
        frame_d = frame_q;
        color_d = color_q;
        done_d  = 1'b0;
        load    = 1'b0;

        if (rst || restart) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
            // One settling cycle after reset places the first pixel WAIT_CYCLES+1 edges out.
            armed_d = (WAIT_CYCLES == 0);
            base_d  = '0;
            phase_d = '0;
            v_d     = '0;
            frame_d = '0;
            color_d = color_f(2'd0, 11'd0, 8'd0, 8'd0);
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (armed_q && !pause) begin
                        if (cnt_q == '0) begin
                            state_d = ST_EMIT;
                            load    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (base_q == BASE_LAST) begin
                            base_d = '0;
                            if (phase_q == PHASE_LAST) begin
                                phase_d = '0;
                                if (v_q == V_LAST) begin
                                    v_d     = '0;
                                    frame_d = frame_q + 8'd1;
                                    done_d  = 1'b1;
                                end else begin
                                    v_d = v_q + 10'd1;
                                end
                            end else begin
                                phase_d = phase_q + 11'd1;
                            end
                        end else begin
                            base_d = base_q + STRIDE_W;
                        end
                        if (WAIT_CYCLES == 0) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            endcase
        end

        h_d     = base_d + phase_d;
        first_d = (h_d == 11'd0) && (v_d == 10'd0);
        valid_d = (state_d == ST_EMIT);
        // Mode is sampled only as a pixel is loaded, so colour stays stable while stalled.
        if (load) begin
            color_d = color_f(mode, h_d, v_d[7:0], frame_d);
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        base_q  <= base_d;
        phase_q <= phase_d;
        h_q     <= h_d;
        v_q     <= v_d;
        frame_q <= frame_d;
        color_q <= color_d;
        first_q <= first_d;
        valid_q <= valid_d;
        done_q  <= done_d;
    end

    assign out_valid    = valid_q;
    assign out_h        = h_q;
    assign out_v        = v_q;
    assign out_color    = color_q;
    assign out_pixel565 = {color_q[23:19], color_q[15:10], color_q[7:3]};
    assign out_frame    = frame_q;
    assign out_first    = first_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_rtx_pattern_gen.sv
// Directed bench: a default-size generator (b) for timing, stall, pause, mode and
// restart, and a tiny back-to-back generator (a) for full-frame scan order.
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s obs=%0h exp=%0h", tag, (obs), (exp)); end end

module tb_rtx_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst, a_restart, a_pause, a_ready;
    logic [1:0]  a_mode;
    logic        a_valid, a_first, a_done;
    logic [10:0] a_h;
    logic [9:0]  a_v;
    logic [23:0] a_color;
    logic [15:0] a_565;
    logic [7:0]  a_frame;

    logic        b_restart, b_pause, b_ready;
    logic [1:0]  b_mode;
    logic        b_valid, b_first, b_done;
    logic [10:0] b_h;
    logic [9:0]  b_v;
    logic [23:0] b_color;
    logic [15:0] b_565;
    logic [7:0]  b_frame;

    rtx_pattern_gen #(.H_SIZE(16), .V_SIZE(2), .STRIDE(4), .WAIT_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .restart(a_restart), .pause(a_pause), .mode(a_mode),
        .out_ready(a_ready), .out_valid(a_valid), .out_h(a_h), .out_v(a_v),
        .out_color(a_color), .out_pixel565(a_565), .out_frame(a_frame),
        .out_first(a_first), .frame_done(a_done)
    );

    rtx_pattern_gen u_b (
        .clk(clk), .rst(rst), .restart(b_restart), .pause(b_pause), .mode(b_mode),
        .out_ready(b_ready), .out_valid(b_valid), .out_h(b_h), .out_v(b_v),
        .out_color(b_color), .out_pixel565(b_565), .out_frame(b_frame),
        .out_first(b_first), .frame_done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until b presents a pixel; n is the number of edges taken.
    task automatic b_next(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_valid && n < 60);
        if (!b_valid) begin
            total++;
            bad++;
            $error("FAIL b_timeout obs=%0d exp=valid", n);
        end
    endtask

    initial begin
        int n;
        int exp_h, exp_v, j;

        rst = 1'b1;
        a_restart = 1'b0; a_pause = 1'b0; a_ready = 1'b0; a_mode = 2'd0;
        b_restart = 1'b0; b_pause = 1'b0; b_ready = 1'b1; b_mode = 2'd0;
        tick();
        tick();

        `CHK("rst_valid", b_valid, 1'b0)
        `CHK("rst_h", b_h, 11'd0)
        `CHK("rst_v", b_v, 10'd0)
        `CHK("rst_frame", b_frame, 8'd0)
        `CHK("rst_first", b_first, 1'b1)
        `CHK("rst_done", b_done, 1'b0)
        `CHK("rst_color", b_color, 24'h0000FF)
        `CHK("rst_565", b_565, 16'h001F)

        rst = 1'b0;
        tick();
        `CHK("a_valid_1edge", a_valid, 1'b1)
        `CHK("b_valid_1edge", b_valid, 1'b0)
        b_next(n);
        `CHK("b_first_latency", n + 1, 17)
        `CHK("b_px0_h", b_h, 11'd0)
        `CHK("b_px0_first", b_first, 1'b1)
        `CHK("b_px0_color", b_color, 24'h0000FF)

        // Stall with pause high: everything holds, valid never drops.
        b_ready = 1'b0; b_pause = 1'b1; b_mode = 2'd2;
        repeat (5) tick();
        `CHK("stall_valid", b_valid, 1'b1)
        `CHK("stall_h", b_h, 11'd0)
        `CHK("stall_color", b_color, 24'h0000FF)
        b_pause = 1'b0; b_ready = 1'b1;
        b_next(n);
        `CHK("gap_nopause", n, 17)
        `CHK("b_px1_h", b_h, 11'd8)
        `CHK("b_px1_color", b_color, 24'h000000)

        b_mode = 2'd1;
        tick();
        b_pause = 1'b1;
        repeat (10) tick();
        `CHK("pause_wait_valid", b_valid, 1'b0)
        b_pause = 1'b0;
        b_next(n);
        `CHK("gap_after_pause", n, 16)
        `CHK("b_px2_h", b_h, 11'd16)
        `CHK("b_px2_color", b_color, 24'h000010)
        `CHK("b_px2_565", b_565, 16'h0002)

        b_mode = 2'd2;
        b_next(n);
        `CHK("b_px3_h", b_h, 11'd24)
        b_next(n);
        `CHK("b_px4_h", b_h, 11'd32)
        `CHK("mode2_color", b_color, 24'hFFFFFF)
        `CHK("mode2_565", b_565, 16'hFFFF)

        // Mode change while stalled must not touch the presented colour.
        b_ready = 1'b0; b_mode = 2'd3;
        repeat (3) tick();
        `CHK("mode_hold_color", b_color, 24'hFFFFFF)
        b_ready = 1'b1;
        for (int k = 5; k <= 32; k++) begin
            b_next(n);
            `CHK("b_scan_h", b_h, 11'(8 * k))
        end
        `CHK("mode3_bar1", b_color, 24'h0000FF)

        // Restart while stalled mid-line.
        b_ready = 1'b0; b_restart = 1'b1;
        tick();
        b_restart = 1'b0;
        `CHK("rs_valid", b_valid, 1'b0)
        `CHK("rs_h", b_h, 11'd0)
        `CHK("rs_v", b_v, 10'd0)
        `CHK("rs_frame", b_frame, 8'd0)
        `CHK("rs_first", b_first, 1'b1)
        `CHK("rs_done", b_done, 1'b0)
        b_ready = 1'b1;
        b_next(n);
        `CHK("rs_latency", n, 17)
        `CHK("rs_px_h", b_h, 11'd0)
        `CHK("rs_px_first", b_first, 1'b1)

        // Small back-to-back instance: one full frame in model order.
        `CHK("a_hold_h", a_h, 11'd0)
        a_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_v = k / 16;
            j = k % 16;
            exp_h = (j % 4) * 4 + j / 4;
            `CHK("a_valid", a_valid, 1'b1)
            `CHK("a_h", a_h, 11'(exp_h))
            `CHK("a_v", a_v, 10'(exp_v))
            `CHK("a_done_low", a_done, 1'b0)
            tick();
        end
        `CHK("a_done_pulse", a_done, 1'b1)
        `CHK("a_frame1", a_frame, 8'd1)
        `CHK("a_wrap_first", a_first, 1'b1)
        repeat (128) tick();
        `CHK("a_frame5", a_frame, 8'd5)
        `CHK("a_f5_h", a_h, 11'd0)
        `CHK("a_f5_color", a_color, 24'h00FFFF)
        `CHK("a_f5_565", a_565, 16'h07FF)
        tick();
        `CHK("a_done_clear", a_done, 1'b0)

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
